// File: rtl/lcd_pkg.sv
// Shared RGB565 LCD definitions: field widths, coordinate type,
// default panel geometry and receiver FSM states.
package lcd_pkg;

    localparam int R_W = 5;
    localparam int G_W = 6;
    localparam int B_W = 5;
    localparam int PIX_W = R_W + G_W + B_W;
    localparam int CRD_W = 16;

    // Panel geometry, shared with the timing generator.
    localparam int H_ACTIVE_DEF = 480;
    localparam int V_ACTIVE_DEF = 272;
    localparam int VGAP_DEF = 1024;
    localparam int LOCK_DEF = 2;

    typedef logic [CRD_W-1:0] crd_t;
    typedef logic [PIX_W-1:0] pix_t;

    localparam crd_t CRD_MAX = '1;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_VBLANK,
        ST_LINE,
        ST_HBLANK
    } rx_state_e;

    function automatic crd_t sat_inc(crd_t v);
        return (v == CRD_MAX) ? v : v + crd_t'(1);
    endfunction

endpackage

// File: rtl/lcd_de_receiver_if.sv
// DE-mode RGB565 input bus plus the recovered pixel stream.
// master = LCD source / stream sink, slave = receiver.
interface lcd_de_receiver_if;
    import lcd_pkg::*;

    logic           LCD_DE;
    logic [R_W-1:0] LCD_R;
    logic [G_W-1:0] LCD_G;
    logic [B_W-1:0] LCD_B;

    logic pix_valid;
    pix_t pix_data;
    crd_t pix_x;
    crd_t pix_y;
    logic sof;
    logic eol;
    logic eof;

    modport master (
        output LCD_DE,
        output LCD_R,
        output LCD_G,
        output LCD_B,
        input  pix_valid,
        input  pix_data,
        input  pix_x,
        input  pix_y,
        input  sof,
        input  eol,
        input  eof
    );

    modport slave (
        input  LCD_DE,
        input  LCD_R,
        input  LCD_G,
        input  LCD_B,
        output pix_valid,
        output pix_data,
        output pix_x,
        output pix_y,
        output sof,
        output eol,
        output eof
    );

endinterface

// File: rtl/lcd_de_edge_gap.sv
// DE edge detector and saturating DE-low run counter with a
// one-shot hit on the clock that completes VGAP_THRESH low clocks.
module lcd_de_edge_gap
    import lcd_pkg::*;
#(
    parameter int VGAP_THRESH = VGAP_DEF
) (
    input  logic PixelClk,
    input  logic RST,
    input  logic de,
    output logic rise,
    output logic fall,
    output logic gap_hit
);

    localparam crd_t HIT_AT = crd_t'(VGAP_THRESH - 1);

    logic de_q;
    crd_t gap_cnt;

    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            de_q    <= 1'b0;
            gap_cnt <= '0;
        end else begin
            de_q <= de;
            if (de) begin
                gap_cnt <= '0;
            end else begin
                gap_cnt <= sat_inc(gap_cnt);
            end
        end
    end

    assign rise = de & ~de_q;
    assign fall = ~de & de_q;
    // gap_cnt holds prior low clocks, so this is the Nth low clock.
    assign gap_hit = ~de & (gap_cnt == HIT_AT);

endmodule

// File: rtl/lcd_de_receiver.sv
// DE-mode RGB565 receiver: recovers pixels with x/y, measures the
// frame format and tracks lock against the expected geometry.
module lcd_de_receiver
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int VGAP_THRESH = VGAP_DEF,
    parameter int LOCK_FRAMES = LOCK_DEF
) (
    input  logic              PixelClk,
    input  logic              RST,
    lcd_de_receiver_if.slave  bus,
    output crd_t              frame_width,
    output crd_t              frame_height,
    output logic              locked,
    output logic              fmt_err
);

    localparam crd_t H_EXP  = crd_t'(H_ACTIVE);
    localparam crd_t V_EXP  = crd_t'(V_ACTIVE);
    localparam crd_t LOCK_N = crd_t'(LOCK_FRAMES);

    logic rise;
    logic fall;
    logic gap_hit;

    lcd_de_edge_gap #(
        .VGAP_THRESH (VGAP_THRESH)
    ) u_edge_gap (
        .PixelClk (PixelClk),
        .RST      (RST),
        .de       (bus.LCD_DE),
        .rise     (rise),
        .fall     (fall),
        .gap_hit  (gap_hit)
    );

    rx_state_e state;
    rx_state_e state_d;

    crd_t x_q;
    crd_t x_d;
    crd_t y_q;
    crd_t y_d;
    crd_t ref_q;
    crd_t ref_d;
    crd_t match_q;
    crd_t match_d;
    logic bad_q;
    logic bad_d;

    logic valid_d;
    logic sof_d;
    logic eol_d;
    logic eof_d;
    logic ferr_d;
    logic lock_d;
    pix_t data_d;
    crd_t px_d;
    crd_t py_d;
    crd_t fw_d;
    crd_t fh_d;

    pix_t pix_in;
    crd_t height;
    crd_t y_inc;
    logic frame_ok;

    assign pix_in = {bus.LCD_R, bus.LCD_G, bus.LCD_B};
    assign height = sat_inc(y_q);
    assign y_inc  = sat_inc(y_q);
    assign frame_ok = (ref_q == H_EXP) && (height == V_EXP) && !bad_q;

    always_comb begin
        state_d = state;
        x_d     = x_q;
        y_d     = y_q;
        ref_d   = ref_q;
        match_d = match_q;
        bad_d   = bad_q;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        eol_d   = 1'b0;
        eof_d   = 1'b0;
        ferr_d  = 1'b0;
        lock_d  = locked;
        data_d  = bus.pix_data;
        px_d    = bus.pix_x;
        py_d    = bus.pix_y;
        fw_d    = frame_width;
        fh_d    = frame_height;

        unique case (state)
            ST_SEARCH: begin
                if (gap_hit) begin
                    state_d = ST_VBLANK;
                end
            end

            ST_VBLANK: begin
                if (rise) begin
                    state_d = ST_LINE;
                    x_d     = crd_t'(1);
                    y_d     = '0;
                    bad_d   = 1'b0;
                    valid_d = 1'b1;
                    sof_d   = 1'b1;
                    data_d  = pix_in;
                    px_d    = '0;
                    py_d    = '0;
                end
            end

            ST_LINE: begin
                if (fall) begin
                    state_d = ST_HBLANK;
                    eol_d   = 1'b1;
                    if (y_q == '0) begin
                        ref_d = x_q;
                    end else if (x_q != ref_q) begin
                        bad_d = 1'b1;
                    end
                end else begin
                    valid_d = 1'b1;
                    data_d  = pix_in;
                    px_d    = x_q;
                    py_d    = y_q;
                    x_d     = sat_inc(x_q);
                    if (x_q == CRD_MAX) begin
                        bad_d = 1'b1;
                    end
                end
            end

            ST_HBLANK: begin
                if (rise) begin
                    state_d = ST_LINE;
                    x_d     = crd_t'(1);
                    y_d     = y_inc;
                    valid_d = 1'b1;
                    data_d  = pix_in;
                    px_d    = '0;
                    py_d    = y_inc;
                    if (y_q == CRD_MAX) begin
                        bad_d = 1'b1;
                    end
                end else if (gap_hit) begin
                    state_d = ST_VBLANK;
                    eof_d   = 1'b1;
                    fw_d    = ref_q;
                    fh_d    = height;
                    if (frame_ok) begin
                        match_d = (match_q >= LOCK_N) ? LOCK_N
                                : match_q + crd_t'(1);
                        lock_d  = (match_d >= LOCK_N);
                    end else begin
                        match_d = '0;
                        lock_d  = 1'b0;
                        ferr_d  = 1'b1;
                    end
                end
            end

            default: state_d = ST_SEARCH;
        endcase
    end

    always_ff @(posedge PixelClk or posedge RST) begin
        if (RST) begin
            state         <= ST_SEARCH;
            x_q           <= '0;
            y_q           <= '0;
            ref_q         <= '0;
            match_q       <= '0;
            bad_q         <= 1'b0;
            bus.pix_valid <= 1'b0;
            bus.pix_data  <= '0;
            bus.pix_x     <= '0;
            bus.pix_y     <= '0;
            bus.sof       <= 1'b0;
            bus.eol       <= 1'b0;
            bus.eof       <= 1'b0;
            frame_width   <= '0;
            frame_height  <= '0;
            locked        <= 1'b0;
            fmt_err       <= 1'b0;
        end else begin
            state         <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            ref_q         <= ref_d;
            match_q       <= match_d;
            bad_q         <= bad_d;
            bus.pix_valid <= valid_d;
            bus.pix_data  <= data_d;
            bus.pix_x     <= px_d;
            bus.pix_y     <= py_d;
            bus.sof       <= sof_d;
            bus.eol       <= eol_d;
            bus.eof       <= eof_d;
            frame_width   <= fw_d;
            frame_height  <= fh_d;
            locked        <= lock_d;
            fmt_err       <= ferr_d;
        end
    end

endmodule
